imm_gen_pipe: RTL



---
 rtl/imm_gen_if.sv | 27 ++
 rtl/imm_gen_pipe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/imm_gen_if.sv
// Handshake bundle for the pipelined immediate generator: upstream fetch side,
// downstream decode side and the pipeline flush.
interface imm_gen_if #(parameter int XLEN = 32);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic [XLEN-1:0] out_target;
   logic            out_illegal;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_pc;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal, out_instr, out_pc
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal, out_instr, out_pc
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate decode and PC-relative target, registered behind a
// one-deep output stage with a single skid slot so in_ready comes from a flop.
module imm_gen_pipe #(
   parameter int XLEN = 32
) (
   input logic clk,
   input logic rst,
   imm_gen_if.slave bus
);
   localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_SHIFT = 3'd2;
   localparam logic [2:0] FMT_S     = 3'd3;
   localparam logic [2:0] FMT_B     = 3'd4;
   localparam logic [2:0] FMT_U     = 3'd5;
   localparam logic [2:0] FMT_J     = 3'd6;

   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic [XLEN-1:0] target;
      logic            illegal;
   } entry_t;

   entry_t dec;
   entry_t out_q;
   entry_t skid_q;
   logic   out_valid_q;
   logic   skid_full_q;
   logic   in_ready_q;
   logic   accept;
   logic   drain;

   logic [6:0]          opcode;
   logic [2:0]          funct3;
   logic                shift_f3;
   logic signed [11:0]  imm_i;
   logic signed [11:0]  imm_s;
   logic signed [12:0]  imm_b;
   logic signed [31:0]  imm_u;
   logic signed [20:0]  imm_j;

   assign opcode   = bus.in_instr[6:0];
   assign funct3   = bus.in_instr[14:12];
   assign shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);
   assign imm_i    = bus.in_instr[31:20];
   assign imm_s    = {bus.in_instr[31:25], bus.in_instr[11:7]};
   assign imm_b    = {bus.in_instr[31], bus.in_instr[7], bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
   assign imm_u    = {bus.in_instr[31:12], 12'b0};
   assign imm_j    = {bus.in_instr[31], bus.in_instr[19:12], bus.in_instr[20], bus.in_instr[30:21], 1'b0};

   always_comb begin
      dec       = '0;
      dec.instr = bus.in_instr;
      dec.pc    = bus.in_pc;
      if (bus.in_instr[1:0] != 2'b11) begin
         dec.illegal = 1'b1;
      end else begin
         case (opcode)
            7'b0000011, 7'b1100111: begin
               dec.fmt = FMT_I;
               dec.imm = XLEN'(imm_i);
            end
            7'b0010011: begin
               if (shift_f3) begin
                  dec.fmt = FMT_SHIFT;
                  dec.imm = XLEN'(bus.in_instr[20 +: SHAMT_W]);
               end else begin
                  dec.fmt = FMT_I;
                  dec.imm = XLEN'(imm_i);
               end
            end
            7'b0011011: begin
               // word-sized ops only exist on RV64 and always use a 5-bit shamt
               if (XLEN != 64) begin
                  dec.illegal = 1'b1;
               end else if (shift_f3) begin
                  dec.fmt = FMT_SHIFT;
                  dec.imm = XLEN'(bus.in_instr[24:20]);
               end else begin
                  dec.fmt = FMT_I;
                  dec.imm = XLEN'(imm_i);
               end
            end
            7'b0100011: begin
               dec.fmt = FMT_S;
               dec.imm = XLEN'(imm_s);
            end
            7'b1100011: begin
               dec.fmt = FMT_B;
               dec.imm = XLEN'(imm_b);
            end
            7'b0110111, 7'b0010111: begin
               dec.fmt = FMT_U;
               dec.imm = XLEN'(imm_u);
            end
            7'b1101111: begin
               dec.fmt = FMT_J;
               dec.imm = XLEN'(imm_j);
            end
            7'b0110011, 7'b0001111, 7'b1110011: dec.fmt = FMT_NONE;
            7'b0111011: dec.illegal = (XLEN != 64);
            default:    dec.illegal = 1'b1;
         endcase
      end
      // JALR target needs rs1, so only B, J and AUIPC are resolved here
      if (dec.fmt == FMT_B || dec.fmt == FMT_J || opcode == OP_AUIPC) begin
         dec.target = bus.in_pc + dec.imm;
      end
   end

   assign accept = bus.in_valid && in_ready_q;
   assign drain  = out_valid_q && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         skid_full_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
         skid_full_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         in_ready_q <= !skid_full_q;
         if (drain && skid_full_q) begin
            out_q       <= skid_q;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
         end else if (accept && (!out_valid_q || drain)) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
         end else if (accept) begin
            skid_q      <= dec;
            skid_full_q <= 1'b1;
            in_ready_q  <= 1'b0;
         end else if (drain) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_imm     = out_q.imm;
   assign bus.out_fmt     = out_q.fmt;
   assign bus.out_target  = out_q.target;
   assign bus.out_illegal = out_q.illegal;
   assign bus.out_instr   = out_q.instr;
   assign bus.out_pc      = out_q.pc;
endmodule
